// File: rtl/sdm_sync_alloc_pkg.sv
// Shared types and helpers for the SDM router switch allocator.
// Port numbering, XY turn legality and free sub-channel search.
package sdm_alloc_pkg;

    localparam int NP   = 5;
    localparam int MAXV = 32;

    typedef enum logic [2:0] {
        P_S = 3'd0,
        P_W = 3'd1,
        P_N = 3'd2,
        P_E = 3'd3,
        P_L = 3'd4
    } port_e;

    typedef struct packed {
        logic found;
        int   idx;
    } free_t;

    function automatic int vw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // X moves first: once a flit travels W/E it may only continue or eject.
    function automatic logic legal_turn(
        input logic [2:0] in_p,
        input logic [2:0] out_p
    );
        logic ok;
        if (out_p > 3'(P_L) || out_p == in_p) begin
            ok = 1'b0;
        end else if (in_p == 3'(P_W) || in_p == 3'(P_E)) begin
            ok = (out_p == 3'(P_W)) || (out_p == 3'(P_E)) ||
                 (out_p == 3'(P_L));
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic free_t lowest_free(input logic [MAXV-1:0] busy);
        free_t f;
        f.found = 1'b0;
        f.idx   = 0;
        for (int i = MAXV - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                f.found = 1'b1;
                f.idx   = i;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/sdm_sync_alloc_if.sv
// Request/grant/crossbar-config bundle between input buffers and allocator.
// master = requester side, slave = allocator side.
interface sdm_sync_alloc_if #(
    parameter int VCN = 4
);
    import sdm_alloc_pkg::*;

    localparam int RN = NP * VCN;
    localparam int IW = $clog2(RN);
    localparam int VW = vw_of(VCN);

    logic [RN-1:0]                   req_vld;
    logic [RN-1:0][2:0]              req_dir;
    logic [RN-1:0]                   rel;
    logic [RN-1:0]                   gnt;
    logic [RN-1:0][VW-1:0]           gnt_vc;
    logic [RN-1:0]                   held;
    logic [NP-1:0][VCN-1:0]          cfg_vld;
    logic [NP-1:0][VCN-1:0][IW-1:0]  cfg_src;
    logic                            err;

    modport master (
        output req_vld, req_dir, rel,
        input  gnt, gnt_vc, held, cfg_vld, cfg_src, err
    );

    modport slave (
        input  req_vld, req_dir, rel,
        output gnt, gnt_vc, held, cfg_vld, cfg_src, err
    );

endinterface

// File: rtl/sdm_sync_alloc_rr_arb.sv
// Round-robin arbiter: one-hot grant from ptr, ptr moves past the winner.
// Pointer only advances on an enabled cycle that actually grants.
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_nxt;
    logic [PW-1:0] w_idx;
    logic [PW:0]   w_sum;
    logic          w_hit;

    always_comb begin
        o_gnt = '0;
        w_hit = 1'b0;
        w_nxt = r_ptr;
        w_sum = '0;
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_hit && i_en && i_req[w_idx]) begin
                w_hit        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                w_nxt = (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_hit) begin
            r_ptr <= w_nxt;
        end
    end

endmodule

// File: rtl/sdm_sync_alloc.sv
// Clocked switch allocator: per-output RR grant onto lowest free sub-channel,
// owner table drives the crossbar config until the holder releases.
module sdm_sync_alloc
    import sdm_alloc_pkg::*;
#(
    parameter int VCN = 4
) (
    input logic             clk,
    input logic             rst,
    sdm_sync_alloc_if.slave bus
);

    localparam int RN = NP * VCN;
    localparam int IW = $clog2(RN);
    localparam int VW = vw_of(VCN);

    logic [RN-1:0]                  r_gnt;
    logic [RN-1:0]                  r_held;
    logic [RN-1:0][VW-1:0]          r_vc;
    logic [NP-1:0][VCN-1:0]         r_cfg_vld;
    logic [NP-1:0][VCN-1:0][IW-1:0] r_cfg_src;
    logic                           r_err;

    logic [RN-1:0]          w_legal;
    logic [RN-1:0]          w_wait;
    logic [RN-1:0]          w_rel;
    logic [RN-1:0]          w_win;
    logic [RN-1:0][VW-1:0]  w_wvc;
    logic [NP-1:0][RN-1:0]  w_cand;
    logic [NP-1:0][RN-1:0]  w_agnt;
    logic [NP-1:0]          w_en;
    logic [NP-1:0]          w_any;
    logic [NP-1:0][VW-1:0]  w_fv;
    logic [NP-1:0][IW-1:0]  w_wsrc;
    logic [NP-1:0][VCN-1:0] w_set;
    logic [NP-1:0][VCN-1:0] w_clr;
    logic                   w_err;

    always_comb begin
        w_legal = '0;
        w_wait  = '0;
        w_rel   = '0;
        w_cand  = '0;
        w_err   = 1'b0;
        for (int r = 0; r < RN; r++) begin
            w_legal[r] = legal_turn(3'(r / VCN), bus.req_dir[r]);
            w_wait[r]  = bus.req_vld[r] && w_legal[r] && !r_held[r];
            w_rel[r]   = bus.rel[r] && r_held[r];
            for (int p = 0; p < NP; p++) begin
                if (w_wait[r] && bus.req_dir[r] == 3'(p)) begin
                    w_cand[p][r] = 1'b1;
                end
            end
            if (bus.req_vld[r] && (!w_legal[r] || r_held[r])) begin
                w_err = 1'b1;
            end
            if (bus.rel[r] && !r_held[r]) begin
                w_err = 1'b1;
            end
        end
    end

    // Unused high bits of the search vector read as busy.
    always_comb begin : free_search
        logic [MAXV-1:0] busy;
        free_t           fr;
        w_en = '0;
        w_fv = '0;
        busy = '1;
        fr   = '0;
        for (int p = 0; p < NP; p++) begin
            busy          = '1;
            busy[VCN-1:0] = r_cfg_vld[p];
            fr            = lowest_free(busy);
            w_en[p]       = fr.found;
            w_fv[p]       = VW'(fr.idx);
        end
    end

    for (genvar gp = 0; gp < NP; gp++) begin : g_arb
        rr_arb #(
            .N (RN)
        ) u_arb (
            .clk   (clk),
            .rst   (rst),
            .i_req (w_cand[gp]),
            .i_en  (w_en[gp]),
            .o_gnt (w_agnt[gp])
        );
    end

    always_comb begin
        w_win  = '0;
        w_wvc  = '0;
        w_any  = '0;
        w_wsrc = '0;
        w_set  = '0;
        w_clr  = '0;
        for (int p = 0; p < NP; p++) begin
            w_any[p] = |w_agnt[p];
            for (int r = 0; r < RN; r++) begin
                if (w_agnt[p][r]) begin
                    w_win[r]  = 1'b1;
                    w_wvc[r]  = w_fv[p];
                    w_wsrc[p] = IW'(r);
                end
            end
            for (int v = 0; v < VCN; v++) begin
                w_set[p][v] = w_any[p] && (w_fv[p] == VW'(v));
                w_clr[p][v] = r_cfg_vld[p][v] && w_rel[r_cfg_src[p][v]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_held    <= '0;
            r_vc      <= '0;
            r_cfg_vld <= '0;
            r_cfg_src <= '0;
            r_err     <= 1'b0;
        end else begin
            r_gnt <= w_win;
            for (int r = 0; r < RN; r++) begin
                if (w_win[r]) begin
                    r_held[r] <= 1'b1;
                    r_vc[r]   <= w_wvc[r];
                end else if (w_rel[r]) begin
                    r_held[r] <= 1'b0;
                    r_vc[r]   <= '0;
                end
            end
            for (int p = 0; p < NP; p++) begin
                for (int v = 0; v < VCN; v++) begin
                    if (w_set[p][v]) begin
                        r_cfg_vld[p][v] <= 1'b1;
                        r_cfg_src[p][v] <= w_wsrc[p];
                    end else if (w_clr[p][v]) begin
                        r_cfg_vld[p][v] <= 1'b0;
                        r_cfg_src[p][v] <= '0;
                    end
                end
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.held    = r_held;
    assign bus.gnt_vc  = r_vc;
    assign bus.cfg_vld = r_cfg_vld;
    assign bus.cfg_src = r_cfg_src;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_sdm_sync_alloc.sv
// Directed vectors, multi-cycle sequences and a random soak for sdm_sync_alloc.
// Requester r = port*4 + vc; ports S=0 W=1 N=2 E=3 L=4.
module tb_sdm_sync_alloc;

    localparam int VCN = 4;
    localparam int NP  = 5;
    localparam int RN  = NP * VCN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sdm_sync_alloc_if #(.VCN(VCN)) bus ();

    sdm_sync_alloc #(.VCN(VCN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rq;
        int dir;
        bit eg;
        bit ee;
    } vec_t;

    vec_t tbl [15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, a, e);
        end
    endtask

    task automatic clr_in();
        bus.req_vld = '0;
        bus.req_dir = '0;
        bus.rel     = '0;
    endtask

    task automatic rst_dut();
        clr_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic req(input int r, input int d);
        bus.req_vld[r] = 1'b1;
        bus.req_dir[r] = 3'(d);
    endtask

    function automatic logic [2:0] rand_dir(input int p);
        int d;
        if (p == 1 || p == 3) begin
            return ($urandom_range(1) == 0) ? 3'(4 - p) : 3'd4;
        end
        d = $urandom_range(4);
        while (d == p) d = $urandom_range(4);
        return 3'(d);
    endfunction

    task automatic soak(input int ncyc);
        logic [RN-1:0] pend;
        logic [RN-1:0] hm;
        logic [RN-1:0] used;
        logic [2:0]    dm [RN];
        int            wc [RN];
        int            pg [NP];
        int            s;
        int            nfail;
        bit            ok;
        string         why;
        pend  = '0;
        hm    = '0;
        nfail = 0;
        for (int r = 0; r < RN; r++) begin
            dm[r] = '0;
            wc[r] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            bus.rel = '0;
            for (int r = 0; r < RN; r++) begin
                if (hm[r]) begin
                    if ($urandom_range(5) == 0) begin
                        bus.rel[r] = 1'b1;
                        hm[r]      = 1'b0;
                    end
                end else if (!pend[r] && $urandom_range(2) == 0) begin
                    dm[r]   = rand_dir(r / VCN);
                    pend[r] = 1'b1;
                    req(r, int'(dm[r]));
                end
            end
            step();
            ok  = 1'b1;
            why = "";
            for (int p = 0; p < NP; p++) pg[p] = 0;
            for (int g = 0; g < RN; g++) begin
                if (bus.gnt[g]) begin
                    if (!pend[g]) begin ok = 0; why = "gnt_unreq"; end
                    pg[dm[g]]++;
                    for (int r = 0; r < RN; r++) begin
                        if (pend[r] && dm[r] == dm[g]) wc[r]++;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (pg[p] > 1) begin ok = 0; why = "two_gnt_port"; end
            end
            for (int g = 0; g < RN; g++) begin
                if (bus.gnt[g] && pend[g]) begin
                    if (wc[g] > RN) begin ok = 0; why = "starve"; end
                    wc[g]          = 0;
                    pend[g]        = 1'b0;
                    hm[g]          = 1'b1;
                    bus.req_vld[g] = 1'b0;
                end
            end
            if (bus.held !== hm) begin ok = 0; why = "held"; end
            used = '0;
            for (int p = 0; p < NP; p++) begin
                for (int v = 0; v < VCN; v++) begin
                    if (bus.cfg_vld[p][v]) begin
                        s = int'(bus.cfg_src[p][v]);
                        if (s >= RN) begin
                            ok = 0; why = "src_range";
                        end else begin
                            if (used[s]) begin ok = 0; why = "src_dup"; end
                            used[s] = 1'b1;
                            if (!hm[s] || int'(dm[s]) != p ||
                                int'(bus.gnt_vc[s]) != v) begin
                                ok = 0; why = "owner";
                            end
                        end
                    end
                end
            end
            if ($countones(bus.cfg_vld) != $countones(hm)) begin
                ok = 0; why = "cfg_count";
            end
            if (bus.err !== 1'b0) begin ok = 0; why = "soak_err"; end
            checks++;
            if (!ok) begin
                errors++;
                if (nfail < 10) begin
                    $display("FAIL soak_%s cyc=%0d held=%0h exp=%0h",
                             why, c, bus.held, hm);
                end
                nfail++;
            end
        end
        clr_in();
    endtask

    initial begin
        logic [RN-1:0] seen;
        int            w4 [4];

        tbl[0]  = '{0, 3, 1, 0};
        tbl[1]  = '{0, 0, 0, 1};
        tbl[2]  = '{0, 2, 1, 0};
        tbl[3]  = '{4, 2, 0, 1};
        tbl[4]  = '{4, 3, 1, 0};
        tbl[5]  = '{4, 4, 1, 0};
        tbl[6]  = '{4, 0, 0, 1};
        tbl[7]  = '{12, 1, 1, 0};
        tbl[8]  = '{12, 2, 0, 1};
        tbl[9]  = '{8, 2, 0, 1};
        tbl[10] = '{8, 0, 1, 0};
        tbl[11] = '{16, 4, 0, 1};
        tbl[12] = '{16, 1, 1, 0};
        tbl[13] = '{1, 5, 0, 1};
        tbl[14] = '{1, 7, 0, 1};
        w4 = '{0, 8, 16, 17};

        // reset with random stimulus
        clr_in();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_vld = RN'($urandom);
            bus.req_dir = (RN*3)'({$urandom, $urandom});
            bus.rel     = RN'($urandom);
            step();
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_held", bus.held, 0);
            chk("rst_cfg", bus.cfg_vld, 0);
            chk("rst_misc", {bus.gnt_vc, bus.cfg_src, bus.err}, 0);
        end

        for (int i = 0; i < 15; i++) begin
            rst_dut();
            req(tbl[i].rq, tbl[i].dir);
            step();
            chk($sformatf("vec%0d_gnt", i), bus.gnt[tbl[i].rq], tbl[i].eg);
            chk($sformatf("vec%0d_held", i), bus.held[tbl[i].rq],
                tbl[i].eg);
            chk($sformatf("vec%0d_err", i), bus.err, tbl[i].ee);
        end

        // single path, release, mid-connection reset
        rst_dut();
        req(0, 3);
        step();
        bus.req_vld[0] = 1'b0;
        chk("p_gnt", bus.gnt, RN'(1));
        chk("p_cfg", bus.cfg_vld, 64'(1) << 12);
        chk("p_src", bus.cfg_src[3][0], 0);
        chk("p_vc", bus.gnt_vc[0], 0);
        step();
        chk("p_pulse", bus.gnt, 0);
        chk("p_hold", bus.held, RN'(1));
        step();
        step();
        step();
        bus.rel[0] = 1'b1;
        step();
        bus.rel[0] = 1'b0;
        chk("p_rel_cfg", bus.cfg_vld, 0);
        chk("p_rel_held", bus.held, 0);
        req(0, 3);
        step();
        bus.req_vld[0] = 1'b0;
        chk("p_regnt", bus.cfg_vld[3][0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("p_midrst_cfg", bus.cfg_vld, 0);
        chk("p_midrst_held", bus.held, 0);

        // contention then full port
        rst_dut();
        for (int k = 0; k < 4; k++) req(w4[k], 3);
        for (int k = 0; k < 4; k++) begin
            step();
            bus.req_vld[w4[k]] = 1'b0;
            chk($sformatf("c_gnt%0d", k), bus.gnt, RN'(1) << w4[k]);
            chk($sformatf("c_vc%0d", k), bus.gnt_vc[w4[k]], k);
            chk($sformatf("c_src%0d", k), bus.cfg_src[3][k], w4[k]);
        end
        req(2, 3);
        seen = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen |= bus.gnt;
        end
        chk("c_full_wait", seen, 0);
        bus.rel[8] = 1'b1;
        step();
        bus.rel[8] = 1'b0;
        chk("c_rel_nobypass", bus.gnt[2], 0);
        chk("c_rel_free", bus.cfg_vld[3][1], 0);
        step();
        bus.req_vld[2] = 1'b0;
        chk("c_late_gnt", bus.gnt, RN'(1) << 2);
        chk("c_late_vc", bus.gnt_vc[2], 1);
        chk("c_late_src", bus.cfg_src[3][1], 2);
        chk("c_err", bus.err, 0);

        // illegal turns beside a legal one
        rst_dut();
        req(4, 2);
        req(8, 2);
        req(0, 3);
        step();
        bus.req_vld[0] = 1'b0;
        chk("i_legal_gnt", bus.gnt, RN'(1));
        seen = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen |= bus.gnt;
        end
        chk("i_never", seen, 0);
        chk("i_err", bus.err, 1);
        chk("i_cfgN", bus.cfg_vld[2], 0);

        // parallel grants, stray release
        rst_dut();
        req(0, 3);
        req(8, 1);
        step();
        clr_in();
        chk("par_gnt", bus.gnt, (RN'(1) << 8) | RN'(1));
        chk("par_err", bus.err, 0);
        bus.rel[5] = 1'b1;
        step();
        bus.rel[5] = 1'b0;
        chk("stray_err", bus.err, 1);
        chk("stray_held", bus.held, (RN'(1) << 8) | RN'(1));
        chk("stray_cfg", bus.cfg_vld, (64'(1) << 12) | (64'(1) << 4));

        rst_dut();
        soak(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
